// File: rtl/serializer_tx.sv
// serializer_tx: parallel-to-serial transmitter with an input FIFO.
//
// Words written through a DEPTH-entry FIFO are shifted out MSB first. Each
// serial bit lasts DIV clocks. Back-to-back words are sent without gaps.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   data_in    in   parallel word to send
//   load       in   write data_in into FIFO when ready=1
//   ready      out  FIFO not full (combinational from FIFO count)
//   flush      in   synchronous abort of FIFO and current word
//   ser_out    out  serial bit, MSB first, held between strobes
//   data_ready out  one-clock strobe qualifying ser_out
//   done       out  one-clock pulse with the last bit of a word
//   busy       out  word in transmission
//   overflow   out  one-clock pulse after a load was dropped
module serializer_tx #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV    = 1,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load,
    output logic              ready,
    input  logic              flush,
    output logic              ser_out,
    output logic              data_ready,
    output logic              done,
    output logic              busy,
    output logic              overflow
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic {StIdle, StShift} state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_avail;
    logic [DATA_W-1:0] r_shift;
    logic [DIV_W-1:0]  r_div_cnt;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic              r_ser;
    logic              r_dr;
    logic              r_done;
    logic              r_busy;
    logic              r_ovf;

    logic              w_push;
    logic              w_pop;
    logic              w_nonempty;
    logic              w_tick;
    logic              w_last;
    logic              w_start;
    logic [DATA_W-1:0] w_head;

    // ready comes from the pre-edge count, so a same-edge pop never frees a slot.
    assign ready      = (r_count < CNT_W'(DEPTH));
    assign w_push     = load && ready && !flush;
    assign w_nonempty = (r_count != '0);
    assign w_tick     = (r_state == StShift) && (r_div_cnt == DIV_W'(DIV - 1));
    assign w_last     = w_tick && (r_bit_cnt == BIT_W'(DATA_W - 1));
    // r_avail lags the count by one clock: an idle start waits one extra cycle
    // so the first strobe lands DIV+2 edges after the word was accepted.
    assign w_start    = (r_state == StIdle) && r_avail && w_nonempty;
    assign w_pop      = !flush && (w_start || (w_last && w_nonempty));
    assign w_head     = r_mem[r_rd_ptr];

    // FIFO storage (no reset needed, validity is tracked by the count).
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // FIFO pointers, count and overflow flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_avail  <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_avail  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            r_avail <= w_nonempty;
            r_ovf   <= load && !ready;
        end
    end

    // Transmit FSM with registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= StIdle;
            r_shift   <= '0;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_ser     <= 1'b0;
            r_dr      <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else if (flush) begin
            // ser_out deliberately keeps its last value.
            r_state   <= StIdle;
            r_shift   <= '0;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_dr      <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_dr   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_start) begin
                        r_shift   <= w_head;
                        r_div_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= StShift;
                        r_busy    <= 1'b1;
                    end
                end
                StShift: begin
                    if (w_tick) begin
                        r_ser     <= r_shift[DATA_W-1];
                        r_dr      <= 1'b1;
                        r_shift   <= r_shift << 1;
                        r_div_cnt <= '0;
                        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        if (w_last) begin
                            r_done <= 1'b1;
                            if (w_nonempty) begin
                                // Gapless hand-over to the next queued word.
                                r_shift   <= w_head;
                                r_bit_cnt <= '0;
                            end else begin
                                r_state <= StIdle;
                                r_busy  <= 1'b0;
                            end
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ser_out    = r_ser;
    assign data_ready = r_dr;
    assign done       = r_done;
    assign busy       = r_busy;
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_serializer_tx.sv
// tb_serializer_tx: self-checking bench for serializer_tx.
//
// A schedule-based reference model predicts, for every accepted word, the
// edge of its first strobe and hence all its strobes; outputs after each edge
// follow from that schedule. Directed cases pin the model with literal values,
// then a randomized run with flushes and resets is checked every cycle.
module tb_serializer_tx;

    localparam int DATA_W = 8;
    localparam int DIV    = 3;
    localparam int DEPTH  = 4;
    localparam int MAXW   = 2048;
    localparam int NEVER  = 32'h7fff_ffff;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [DATA_W-1:0] data_in;
    logic              load;
    logic              flush;
    logic              ready;
    logic              ser_out;
    logic              data_ready;
    logic              done;
    logic              busy;
    logic              overflow;

    serializer_tx #(
        .DATA_W(DATA_W),
        .DIV   (DIV),
        .DEPTH (DEPTH)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .data_in   (data_in),
        .load      (load),
        .ready     (ready),
        .flush     (flush),
        .ser_out   (ser_out),
        .data_ready(data_ready),
        .done      (done),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int                e        = 0;
    int                w_n      = 0;
    int                w_acc   [MAXW];
    int                w_start [MAXW];
    int                w_kill  [MAXW];
    logic [DATA_W-1:0] w_data  [MAXW];
    int                last_end = -1000;
    int                m_pre;
    int                m_d;
    logic [DATA_W-1:0] m_w;
    logic              exp_dr    = 1'b0;
    logic              exp_done  = 1'b0;
    logic              exp_busy  = 1'b0;
    logic              exp_ovf   = 1'b0;
    logic              exp_ser   = 1'b0;
    logic              exp_ready = 1'b1;

    // Words held in the FIFO just after edge x (accepted, not yet popped,
    // not flushed). A word is popped DIV edges before its first strobe.
    function automatic int occ(input int x);
        int c = 0;
        for (int i = 0; i < w_n; i++) begin
            if (w_acc[i] <= x && (w_start[i] - DIV) > x && w_kill[i] > x) c++;
        end
        return c;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_n       = 0;
            last_end  = -1000;
            exp_dr    = 1'b0;
            exp_done  = 1'b0;
            exp_busy  = 1'b0;
            exp_ovf   = 1'b0;
            exp_ser   = 1'b0;
            exp_ready = 1'b1;
        end else begin
            e       = e + 1;
            m_pre   = occ(e - 1);
            exp_ovf = 1'b0;
            if (flush) begin
                for (int i = 0; i < w_n; i++) begin
                    if (w_kill[i] > e) w_kill[i] = e;
                end
                last_end = -1000;
            end else if (load) begin
                if (m_pre < DEPTH) begin
                    if (w_n < MAXW) begin
                        w_acc[w_n]   = e;
                        w_data[w_n]  = data_in;
                        // Queued behind a running word: gapless; else idle start.
                        w_start[w_n] = (e < last_end) ? last_end + DIV : e + DIV + 2;
                        w_kill[w_n]  = NEVER;
                        last_end     = w_start[w_n] + (DATA_W - 1) * DIV;
                        w_n++;
                    end
                end else begin
                    exp_ovf = 1'b1;
                end
            end
            exp_dr   = 1'b0;
            exp_done = 1'b0;
            exp_busy = 1'b0;
            for (int i = 0; i < w_n; i++) begin
                if (e < w_kill[i]) begin
                    if (e >= w_start[i] - DIV && e < w_start[i] + (DATA_W - 1) * DIV)
                        exp_busy = 1'b1;
                    m_d = e - w_start[i];
                    if (m_d >= 0 && (m_d % DIV) == 0 && (m_d / DIV) < DATA_W) begin
                        m_w      = w_data[i];
                        exp_dr   = 1'b1;
                        exp_ser  = m_w[DATA_W - 1 - m_d / DIV];
                        exp_done = ((m_d / DIV) == DATA_W - 1);
                    end
                end
            end
            exp_ready = (occ(e) < DEPTH);
        end
    end

    // ---------------- checking helpers ----------------
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_ovf    = 0;
    int   s_edge [$];
    logic s_bit  [$];
    logic s_done [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare every output with the model.
    task automatic tick();
        @(negedge clk);
        if (reset_n) begin
            check("data_ready", 32'(data_ready), 32'(exp_dr));
            check("ser_out", 32'(ser_out), 32'(exp_ser));
            check("done", 32'(done), 32'(exp_done));
            check("busy", 32'(busy), 32'(exp_busy));
            check("ready", 32'(ready), 32'(exp_ready));
            check("overflow", 32'(overflow), 32'(exp_ovf));
            if (data_ready) begin
                s_edge.push_back(e);
                s_bit.push_back(ser_out);
                s_done.push_back(done);
            end
            if (overflow) n_ovf++;
        end
    endtask

    task automatic clear_log();
        s_edge.delete();
        s_bit.delete();
        s_done.delete();
        n_ovf = 0;
    endtask

    // Called at a falling edge; asserts reset mid-phase and checks outputs at once.
    task automatic do_reset();
        load  = 1'b0;
        flush = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("rst ser_out", 32'(ser_out), 32'd0);
        check("rst data_ready", 32'(data_ready), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst overflow", 32'(overflow), 32'd0);
        check("rst ready", 32'(ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        clear_log();
    endtask

    task automatic send(input logic [DATA_W-1:0] d, output int acc);
        data_in = d;
        load    = 1'b1;
        tick();
        acc  = e;
        load = 1'b0;
    endtask

    task automatic wait_strobes(input int n);
        int k = 0;
        while (s_edge.size() < n && k < 300) begin
            tick();
            k++;
        end
        check("strobe count reached", 32'(s_edge.size()), 32'(n));
    endtask

    function automatic logic [31:0] pack_bits(input int first, input int cnt);
        logic [31:0] v = '0;
        for (int i = first; i < first + cnt; i++) begin
            v = v << 1;
            if (i < s_bit.size()) v[0] = s_bit[i];
        end
        return v;
    endfunction

    function automatic logic [31:0] pack_done(input int first, input int cnt);
        logic [31:0] v = '0;
        for (int i = first; i < first + cnt; i++) begin
            v = v << 1;
            if (i < s_done.size()) v[0] = s_done[i];
        end
        return v;
    endfunction

    function automatic int gap_errors();
        int c = 0;
        for (int i = 1; i < s_edge.size(); i++) begin
            if (s_edge[i] - s_edge[i-1] != DIV) c++;
        end
        return c;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int          acc;
        logic [5:0]  rdy_vec;
        reset_n = 1'b0;
        load    = 1'b0;
        flush   = 1'b0;
        data_in = '0;
        #2;
        check("init ser_out", 32'(ser_out), 32'd0);
        check("init busy", 32'(busy), 32'd0);
        check("init ready", 32'(ready), 32'd1);
        check("init data_ready", 32'(data_ready), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Single word 0xA5 from idle.
        clear_log();
        send(8'hA5, acc);
        for (int i = 0; i < 40; i++) tick();
        check("A5 strobes", 32'(s_edge.size()), 32'd8);
        check("A5 latency", 32'(s_edge[0] - acc), 32'd5);
        check("A5 gaps", 32'(gap_errors()), 32'd0);
        check("A5 bits", pack_bits(0, 8), 32'hA5);
        check("A5 done", pack_done(0, 8), 32'h01);
        check("A5 busy after", 32'(busy), 32'd0);

        // Two words on consecutive clocks go out back to back.
        clear_log();
        data_in = 8'h3C;
        load    = 1'b1;
        tick();
        acc     = e;
        data_in = 8'hC3;
        tick();
        load    = 1'b0;
        for (int i = 0; i < 70; i++) tick();
        check("pair strobes", 32'(s_edge.size()), 32'd16);
        check("pair latency", 32'(s_edge[0] - acc), 32'd5);
        check("pair gaps", 32'(gap_errors()), 32'd0);
        check("pair bits", pack_bits(0, 16), 32'h3CC3);
        check("pair done", pack_done(0, 16), 32'h0101);

        // Six loads into a 4-deep FIFO: the sixth is dropped.
        do_reset();
        rdy_vec = '0;
        for (int k = 1; k <= 6; k++) begin
            rdy_vec = {rdy_vec[4:0], ready};
            data_in = 8'(k);
            load    = 1'b1;
            tick();
        end
        load = 1'b0;
        wait_strobes(40);
        for (int i = 0; i < 20; i++) tick();
        check("fill ready pattern", 32'(rdy_vec), 32'b111110);
        check("fill overflow pulses", 32'(n_ovf), 32'd1);
        check("fill strobes", 32'(s_edge.size()), 32'd40);
        check("fill gaps", 32'(gap_errors()), 32'd0);
        for (int k = 0; k < 5; k++) begin
            check("fill word", pack_bits(8 * k, 8), 32'(k + 1));
            check("fill done", pack_done(8 * k, 8), 32'h01);
        end

        // Reset in the middle of 0xFF, then a fresh 0x80.
        do_reset();
        send(8'hFF, acc);
        wait_strobes(3);
        check("FF third bit", 32'(ser_out), 32'd1);
        do_reset();
        for (int i = 0; i < 30; i++) tick();
        check("no strobes after reset", 32'(s_edge.size()), 32'd0);
        send(8'h80, acc);
        wait_strobes(8);
        check("80 latency", 32'(s_edge[0] - acc), 32'd5);
        check("80 bits", pack_bits(0, 8), 32'h80);
        check("80 gaps", 32'(gap_errors()), 32'd0);

        // Flush during 0x55 with 0xAA queued.
        do_reset();
        data_in = 8'h55;
        load    = 1'b1;
        tick();
        data_in = 8'hAA;
        tick();
        load = 1'b0;
        wait_strobes(2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy", 32'(busy), 32'd0);
        check("flush ready", 32'(ready), 32'd1);
        check("flush data_ready", 32'(data_ready), 32'd0);
        check("flush ser_out held", 32'(ser_out), 32'd1);
        for (int i = 0; i < 60; i++) tick();
        check("flush strobes total", 32'(s_edge.size()), 32'd2);

        // Randomized traffic with occasional flush and reset.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (i % 500 == 250) do_reset();
            data_in = 8'($urandom);
            if (((i / 100) % 2) == 0) load = ($urandom_range(0, 99) < 45);
            else                      load = ($urandom_range(0, 99) < 4);
            flush = ($urandom_range(0, 99) == 0);
            tick();
        end
        load  = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < 150; i++) tick();
        check("drained busy", 32'(busy), 32'd0);
        check("drained ready", 32'(ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
